seg_pattern_rx: RTL and testbench
=================================

Name: seg_pattern_rx

Overview:
- Reverse direction of the hex-to-7-segment path: watches the seven individual segment lines driven by the segment encoder, qualifies a pattern once it is stable, and decodes it back to a 4-bit hex value.
- Flags patterns that are not legal glyphs and keeps a count of them.
- Used as an on-chip loopback checker for the display path and as a self-checking monitor in display benches.

Parameters:
- STABLE_CYC, 4, consecutive identical samples required before a pattern is accepted; legal range 1..255.
- ERR_W, 8, width of the saturating illegal-pattern counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sega..segg  in  1 each  segment lines a..g, active-high (1 = lit), same clock domain as clk.
- hex_out  out  4  last accepted decoded value.
- valid  out  1  one-cycle pulse when a new pattern is accepted.
- changed  out  1  high with valid when the accepted 7-bit pattern differs from the previously accepted one.
- blank  out  1  level: last accepted pattern was 0000000.
- err  out  1  level: last accepted pattern was neither a legal glyph nor blank.
- err_cnt  out  ERR_W  saturating count of accepted illegal patterns.
- locked  out  1  level: FSM in LOCKED.

Behaviour:
- Reset (async assert, sync release on clk):
  - hex_out=0, valid=0, changed=0, blank=0, err=0, err_cnt=0, locked=0.
  - Sample register = 0000000, stability counter = 0, last-accepted register = 0000000, FSM = IDLE.
- Segment vector order is {a,b,c,d,e,f,g}.
- Legal glyphs:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Sampling and stability counter:
  - Each cycle the input vector is registered into seg_q.
  - Counter increments, saturating at STABLE_CYC, when input == seg_q; clears to 0 when input != seg_q.
- FSM:
  - IDLE -> SETTLE on the first cycle after reset.
  - SETTLE -> LOCKED when the counter reaches STABLE_CYC-1 while input == seg_q. On that edge the registered outputs update and valid is asserted for exactly one cycle.
  - LOCKED -> SETTLE on any cycle where input != seg_q. Outputs hex_out/blank/err hold their last accepted values; locked drops the following cycle.
  - LOCKED with no input change: no further valid pulses.
- Latency: after a pattern change is first sampled into seg_q at edge N, valid is high during the cycle following edge N+STABLE_CYC.
- On acceptance:
  - Legal glyph: hex_out = glyph value; blank=0; err=0.
  - Blank: hex_out holds its previous value; blank=1; err=0.
  - Illegal: hex_out holds; err=1; blank=0; err_cnt += 1, saturating at all-ones.
  - changed = (accepted pattern != last-accepted register); the register is then updated.
- Glitch shorter than STABLE_CYC samples: no valid. Re-settling to the same pattern produces valid with changed=0.
- STABLE_CYC=1: accept on the first cycle the input equals seg_q.
- Reset mid-SETTLE: all state is cleared immediately and no valid is emitted.

Test Plan:
1. STABLE_CYC=4; reset, then drive 1111110 (0) and hold -> exactly one valid, with hex_out=0, changed=1, err=0, locked=1 after it; no further valid while held.
2. Step through all 16 legal glyphs, each held 10 cycles -> 16 valid pulses, hex_out = 0..F in order, each with changed=1 and 5-cycle latency from the change.
3. Hold 0110000 (1), glitch to 1111111 for 2 cycles, return to 0110000 -> no valid during the glitch; one valid on re-settle with hex_out=1, changed=0.
4. Drive 1010101 held, then 0000000 held -> first valid has err=1, err_cnt=1, hex_out unchanged; second has blank=1, err=0, hex_out unchanged.
5. ERR_W=2; accept 5 different illegal patterns -> err_cnt saturates at 3.
6. Assert rst_n=0 two cycles into settling 1001111 -> all outputs go to 0 asynchronously, no valid pulse; after release, holding the pattern yields valid with hex_out=E.

Source files
------------

// File: rtl/seg_pattern_rx.sv
// Seven-segment pattern receiver: qualifies a stable segment pattern, decodes it
// back to a hex digit, and flags/counts patterns that are not legal glyphs.
module seg_pattern_rx #(
  parameter int STABLE_CYC = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sega,
  input  logic             segb,
  input  logic             segc,
  input  logic             segd,
  input  logic             sege,
  input  logic             segf,
  input  logic             segg,
  output logic [3:0]       hex_out,
  output logic             valid,
  output logic             changed,
  output logic             blank,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);
  localparam logic [7:0] ACC_TH  = 8'(STABLE_CYC - 1);

  state_t     state, state_nxt;
  logic [6:0] seg_in;
  logic [6:0] seg_q;
  logic [6:0] last_q;
  logic [7:0] cnt;
  logic       same;
  logic       accept;
  logic [4:0] dec;

  // Returns {legal, value}; legal=0 for blank and for any non-glyph pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b1001110: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1001111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  assign seg_in = {sega, segb, segc, segd, sege, segf, segg};
  assign same   = (seg_in == seg_q);
  assign dec    = decode(seg_in);
  assign locked = (state == LOCKED);

  // Threshold compare uses >= so a count that advanced during IDLE still accepts.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:   state_nxt = SETTLE;
      SETTLE: if (same && cnt >= ACC_TH) begin
        accept    = 1'b1;
        state_nxt = LOCKED;
      end
      LOCKED: if (!same) state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample stage: input register and stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      seg_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      seg_q <= seg_in;
      if (!same) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
    end
  end

  // Accept stage: decoded outputs and illegal-pattern counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
      blank   <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      last_q  <= '0;
    end else begin
      valid   <= accept;
      changed <= accept && (seg_in != last_q);
      if (accept) begin
        last_q <= seg_in;
        if (dec[4]) begin
          hex_out <= dec[3:0];
          blank   <= 1'b0;
          err     <= 1'b0;
        end else if (seg_in == 7'b0000000) begin
          blank <= 1'b1;
          err   <= 1'b0;
        end else begin
          blank <= 1'b0;
          err   <= 1'b1;
          if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_pattern_rx.sv
// Bench for seg_pattern_rx: two instances (STABLE_CYC=4/ERR_W=8 and
// STABLE_CYC=1/ERR_W=2) share stimulus and are checked against a run-length model.
module tb_seg_pattern_rx;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;

  logic [3:0] hex0, hex1;
  logic       valid0, valid1, changed0, changed1, blank0, blank1, err0, err1;
  logic       locked0, locked1;
  logic [7:0] ecnt0;
  logic [1:0] ecnt1;

  int total = 0;
  int bad   = 0;

  seg_pattern_rx #(.STABLE_CYC(4), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n),
    .sega(seg[6]), .segb(seg[5]), .segc(seg[4]), .segd(seg[3]),
    .sege(seg[2]), .segf(seg[1]), .segg(seg[0]),
    .hex_out(hex0), .valid(valid0), .changed(changed0), .blank(blank0),
    .err(err0), .err_cnt(ecnt0), .locked(locked0)
  );

  seg_pattern_rx #(.STABLE_CYC(1), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .sega(seg[6]), .segb(seg[5]), .segc(seg[4]), .segd(seg[3]),
    .sege(seg[2]), .segf(seg[1]), .segg(seg[0]),
    .hex_out(hex1), .valid(valid1), .changed(changed1), .blank(blank1),
    .err(err1), .err_cnt(ecnt1), .locked(locked1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model state: a pattern is accepted once the same sample has been seen
  // STABLE_CYC+1 times in a row (the reset value of the sample register counts),
  // at most once per run, and never on the first edge after reset.
  int         sc   [2] = '{4, 1};
  int         emax [2] = '{255, 3};
  logic [6:0] m_prev [2];
  logic [6:0] m_last [2];
  int         m_run  [2];
  int         m_k    [2];
  bit         m_acc  [2];
  logic [3:0] m_hex  [2];
  bit         m_valid[2];
  bit         m_chg  [2];
  bit         m_blank[2];
  bit         m_err  [2];
  int         m_ecnt [2];
  int         vcount [2];

  function automatic int lookup(input logic [6:0] p);
    for (int g = 0; g < 16; g++) if (glyph[g] == p) return g;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = '0; m_last[i] = '0; m_run[i] = 1; m_k[i] = 0; m_acc[i] = 0;
      m_hex[i] = '0; m_valid[i] = 0; m_chg[i] = 0; m_blank[i] = 0; m_err[i] = 0;
      m_ecnt[i] = 0;
    end
  endtask

  task automatic model_step();
    int g;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0;
      m_chg[i]   = 0;
      if (seg == m_prev[i]) begin
        if (m_run[i] < 1000) m_run[i]++;
      end else begin
        m_run[i] = 1;
        m_acc[i] = 0;
      end
      if (m_k[i] > 0 && !m_acc[i] && m_run[i] >= sc[i] + 1) begin
        m_acc[i]   = 1;
        m_valid[i] = 1;
        m_chg[i]   = (seg != m_last[i]);
        m_last[i]  = seg;
        g = lookup(seg);
        if (g >= 0) begin
          m_hex[i] = 4'(g); m_blank[i] = 0; m_err[i] = 0;
        end else if (seg == 7'b0000000) begin
          m_blank[i] = 1; m_err[i] = 0;
        end else begin
          m_blank[i] = 0; m_err[i] = 1;
          if (m_ecnt[i] < emax[i]) m_ecnt[i]++;
        end
      end
      m_prev[i] = seg;
      if (m_k[i] < 2) m_k[i]++;
    end
  endtask

  task automatic compare();
    logic [15:0] act, exp;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) act = {hex0, valid0, changed0, blank0, err0, locked0, ecnt0, 2'b00};
      else        act = {hex1, valid1, changed1, blank1, err1, locked1, 6'd0, ecnt1, 2'b00};
      exp = {m_hex[i], m_valid[i], m_chg[i], m_blank[i], m_err[i], m_acc[i],
             8'(m_ecnt[i]), 2'b00};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL outputs u%0d at %0t: got hex/v/c/b/e/l/cnt=%h required %h",
                 i, $time, act, exp);
      end
      if ((i == 0 && valid0) || (i == 1 && valid1)) vcount[i]++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // One clock: model steps on the edge, DUT outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare();
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  // Drive a pattern for 10 cycles and return how many cycles until u0 pulsed valid.
  task automatic step_lat(input logic [6:0] p, output int lat);
    seg = p;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (valid0 && lat < 0) lat = c;
    end
  endtask

  int v0, v1, lat;
  logic [6:0] rp;

  initial begin
    rst_n = 1'b0;
    seg   = 7'b0000000;
    vcount[0] = 0;
    vcount[1] = 0;
    model_reset();

    // Reset state
    repeat (2) cyc();
    chk("reset_hex", int'(hex0), 0);
    chk("reset_locked", int'(locked0), 0);
    chk("reset_errcnt", int'(ecnt0), 0);

    // Glyph 0 held: exactly one valid, then locked
    seg = 7'b1111110;
    v0  = vcount[0];
    rst_n = 1'b1;
    repeat (20) cyc();
    chk("t1_valid_count", vcount[0] - v0, 1);
    chk("t1_hex", int'(hex0), 0);
    chk("t1_locked", int'(locked0), 1);

    // All 16 glyphs in order after a blank
    hold(7'b0000000, 10);
    for (int g = 0; g < 16; g++) begin
      step_lat(glyph[g], lat);
      chk($sformatf("t2_latency_%0d", g), lat, 5);
      chk($sformatf("t2_hex_%0d", g), int'(hex0), g);
    end

    // Glitch on a held 1
    hold(7'b0110000, 10);
    v0 = vcount[0];
    hold(7'b1111111, 2);
    chk("t3_no_valid_glitch", vcount[0] - v0, 0);
    hold(7'b0110000, 10);
    chk("t3_resettle_valid", vcount[0] - v0, 1);
    chk("t3_hex", int'(hex0), 1);

    // Illegal then blank
    hold(7'b1010101, 10);
    chk("t4_err", int'(err0), 1);
    chk("t4_errcnt", int'(ecnt0), 1);
    chk("t4_hex_hold", int'(hex0), 1);
    hold(7'b0000000, 10);
    chk("t4_blank", int'(blank0), 1);
    chk("t4_hex_hold2", int'(hex0), 1);

    // Four more illegals: narrow counter saturates
    hold(7'b1010100, 10);
    hold(7'b0000001, 10);
    hold(7'b1100011, 10);
    hold(7'b0101010, 10);
    chk("t5_errcnt_sat", int'(ecnt1), 3);
    chk("t5_errcnt_wide", int'(ecnt0), 5);

    // Reset mid-settle
    hold(7'b0110000, 10);
    seg = 7'b1001111;
    v0 = vcount[0];
    v1 = vcount[1];
    repeat (3) cyc();
    do_reset(2);
    chk("t6_hex_cleared", int'(hex0), 0);
    chk("t6_no_valid", vcount[0] - v0, 0);
    repeat (12) cyc();
    chk("t6_hex_E", int'(hex0), 14);
    chk("t6_hex_E_s1", int'(hex1), 14);
    chk("t6_valid_after", vcount[0] - v0, 1);

    // Randomised segments with occasional resets
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(3))
        0, 1: rp = glyph[$urandom_range(15)];
        2:    rp = 7'b0000000;
        default: rp = 7'($urandom_range(127));
      endcase
      if ($urandom_range(49) == 0) do_reset($urandom_range(1, 2));
      hold(rp, $urandom_range(1, 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
